// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Instruction fetch sequencer with a 2-entry skid buffer toward decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        idle,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam logic [2:0] c_depth = 3'(BUF_DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] e0_instr_q, e0_instr_d, e0_pc_q, e0_pc_d;
  logic [31:0] e1_instr_q, e1_instr_d, e1_pc_q, e1_pc_d;

  logic        w_pop;
  logic        w_issue;
  logic [2:0]  w_occ;
  logic [31:0] w_l0_instr, w_l0_pc, w_l1_instr, w_l1_pc;

  assign imem_addr = fetch_pc_q;
  assign idle      = halt & ~inflight_q & (count_q == 2'd0);

  // The returning word is visible at the head in its return cycle when the buffer is empty.
  always_comb begin
    out_valid = (count_q != 2'd0) | inflight_q;
    out_instr = 32'h0;
    out_pc    = 32'h0;
    if (count_q != 2'd0) begin
      out_instr = e0_instr_q;
      out_pc    = e0_pc_q;
    end else if (inflight_q) begin
      out_instr = imem_rdata;
      out_pc    = inflight_pc_q;
    end
  end

  assign w_pop   = out_valid & out_ready;
  assign w_occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, w_pop};
  assign w_issue = ~redirect_valid & ~halt & (w_occ < c_depth);

  // Logical queue = stored entries followed by the returning word.
  always_comb begin
    w_l0_instr = imem_rdata;
    w_l0_pc    = inflight_pc_q;
    w_l1_instr = imem_rdata;
    w_l1_pc    = inflight_pc_q;
    if (count_q != 2'd0) begin
      w_l0_instr = e0_instr_q;
      w_l0_pc    = e0_pc_q;
    end
    if (count_q == 2'd2) begin
      w_l1_instr = e1_instr_q;
      w_l1_pc    = e1_pc_q;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = w_occ[1:0];
    e0_instr_d    = e0_instr_q;
    e0_pc_d       = e0_pc_q;
    e1_instr_d    = e1_instr_q;
    e1_pc_d       = e1_pc_q;

    if (w_pop) begin
      e0_instr_d = w_l1_instr;
      e0_pc_d    = w_l1_pc;
    end else begin
      e0_instr_d = w_l0_instr;
      e0_pc_d    = w_l0_pc;
      e1_instr_d = w_l1_instr;
      e1_pc_d    = w_l1_pc;
    end

    if (redirect_valid) begin
      // The pop this cycle still completes; everything behind it is discarded.
      count_d    = 2'd0;
      inflight_d = 1'b0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (w_issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= 2'd0;
      e0_instr_q    <= 32'h0;
      e0_pc_q       <= 32'h0;
      e1_instr_q    <= 32'h0;
      e1_pc_q       <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      e0_instr_q    <= e0_instr_d;
      e0_pc_q       <= e0_pc_d;
      e1_instr_q    <= e1_instr_d;
      e1_pc_q       <= e1_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Scoreboard bench for fetch_ctrl against a sequential-PC stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [31:0] c_reset_pc = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        idle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_push_pc = 32'h0;

  fetch_ctrl #(
    .RESET_PC  (c_reset_pc),
    .BUF_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .idle           (idle),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'hA000_0000 + (pc >> 2);
  endfunction

  // Synchronous-read instruction memory
  always_ff @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: consecutive word PCs from the latest restart point.
  task automatic sb_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(next_push_pc);
      next_push_pc = next_push_pc + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    next_push_pc = pc & ~32'h3;
    sb_fill();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    #1;
    sb_restart(pc);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin : monitor
    logic        hold_v;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic [31:0] exp_pc;
    hold_v     = 1'b0;
    hold_pc    = 32'h0;
    hold_instr = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
          check("stall_hold_pc", out_pc, hold_pc);
          check("stall_hold_instr", out_instr, hold_instr);
        end
        if (!halt) check("idle_low_while_running", {31'b0, idle}, 32'd0);
        if (out_valid && out_ready) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got pc %h expected no transfer", out_pc);
          end else begin
            exp_pc = exp_q.pop_front();
            check("xfer_pc", out_pc, exp_pc);
            check("xfer_instr", out_instr, mem_word(exp_pc));
            sb_fill();
          end
        end
        hold_v     = out_valid && !out_ready && !redirect_valid;
        hold_pc    = out_pc;
        hold_instr = out_instr;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [31:0] a;
    int          budget;
    int          xfer_base;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_imem_addr", imem_addr, c_reset_pc);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_idle", {31'b0, idle}, 32'd0);

    // Startup latency and stall saturation
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sb_restart(c_reset_pc);
    #1;
    check("first_not_early", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc", out_pc, c_reset_pc);
    check("first_instr", out_instr, mem_word(c_reset_pc));
    repeat (5) @(posedge clk);
    #1;
    check("stall_addr_stops", imem_addr, c_reset_pc + 32'd8);
    check("stall_head_pc", out_pc, c_reset_pc);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_no_gap", {31'b0, out_valid}, 32'd1);
    end

    // Redirect with a full buffer
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_redirect(32'h0000_0043);
    out_ready = 1'b1;
    check("redir_bubble", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("redir_valid", {31'b0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h0000_0040);
    check("redir_instr", out_instr, 32'hA000_0010);

    // Alternating backpressure
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;

    // Halt drains, holds the PC, then resumes
    repeat (3) @(posedge clk);
    #1;
    halt   = 1'b1;
    a      = imem_addr;
    budget = 0;
    while (!idle && budget < 6) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("halt_idle", {31'b0, idle}, 32'd1);
    check("halt_idle_latency", {31'b0, (budget <= 2)}, 32'd1);
    check("halt_no_output", {31'b0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("halt_addr_hold", imem_addr, a);
    halt = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Redirect while halted
    halt = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    do_redirect(32'h0000_0100);
    check("halt_redir_addr", imem_addr, 32'h0000_0100);
    check("halt_redir_idle", {31'b0, idle}, 32'd1);
    halt = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Address wrap at the top of memory
    do_redirect(32'hFFFF_FFF6);
    @(posedge clk);
    #1;
    check("wrap_first_pc", out_pc, 32'hFFFF_FFF4);
    repeat (8) @(posedge clk);
    #1;

    // Randomized traffic
    xfer_base = n_xfer;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      halt      = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) begin
        a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | $urandom_range(0, 31)) : $urandom;
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(negedge clk);
        #1;
        sb_restart(a);
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    halt           = 1'b0;
    out_ready      = 1'b1;
    check("random_progress", {31'b0, ((n_xfer - xfer_base) > 100)}, 32'd1);

    // Asynchronous reset with a full buffer
    repeat (4) @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_addr", imem_addr, c_reset_pc);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sb_restart(c_reset_pc);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("restart_valid", {31'b0, out_valid}, 32'd1);
    check("restart_pc", out_pc, c_reset_pc);
    repeat (6) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
